icw_init_sequencer: RTL and testbench



---
 rtl/icw_init_sequencer_pkg.sv | 58 +++++
 rtl/icw_init_sequencer_if.sv | 16 +
 rtl/icw_init_sequencer_write_decode.sv | 47 ++++
 rtl/icw_init_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_icw_init_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/icw_init_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pic_init_pkg
// Shared types and constants for the 8259-style initialization-command-word
// sequencer: sequencer state encoding, ICW1/ICW4 bit positions, encodings of
// the "next expected word" output and the write classification produced by
// icw_write_decode.
// ---------------------------------------------------------------------------
package pic_init_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT2 = 3'd1,
        ST_WAIT3 = 3'd2,
        ST_WAIT4 = 3'd3,
        ST_READY = 3'd4
    } state_e;

    // ICW1 bit positions
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_ADI  = 2;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_ID   = 4;

    // ICW4 bit positions
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;

    // expect_o encodings
    localparam logic [1:0] EXP_ICW1 = 2'd0;
    localparam logic [1:0] EXP_ICW2 = 2'd1;
    localparam logic [1:0] EXP_ICW3 = 2'd2;
    localparam logic [1:0] EXP_ICW4 = 2'd3;

    // Classification of one bus write
    typedef enum logic [2:0] {
        WR_NONE = 3'd0,   // no write this cycle
        WR_ICW1 = 3'd1,   // ICW1: (re)start initialization
        WR_NEXT = 3'd2,   // the ICW the sequencer is waiting for
        WR_OCW  = 3'd3,   // post-init write forwarded as OCW
        WR_ERR  = 3'd4    // illegal write for the current state
    } wr_class_e;

    // Map a state onto the index of the word it is waiting for
    function automatic logic [1:0] expect_of(input state_e st);
        logic [1:0] exp_v;
        case (st)
            ST_WAIT2: exp_v = EXP_ICW2;
            ST_WAIT3: exp_v = EXP_ICW3;
            ST_WAIT4: exp_v = EXP_ICW4;
            default:  exp_v = EXP_ICW1;
        endcase
        return exp_v;
    endfunction

endpackage

// File: rtl/icw_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// icw_init_sequencer_if
// CPU control-write bus from the bus interface into the ICW sequencer.
//   wr_en : one-cycle write strobe
//   a0    : address bit A0 of the write
//   din   : write data D7..D0
// Modports: master (bus interface side, drives) / slave (sequencer side).
// ---------------------------------------------------------------------------
interface icw_init_sequencer_if;
    logic       wr_en;
    logic       a0;
    logic [7:0] din;

    modport master (output wr_en, output a0, output din);
    modport slave  (input  wr_en, input  a0, input  din);
endinterface

// File: rtl/icw_init_sequencer_write_decode.sv
// ---------------------------------------------------------------------------
// icw_write_decode
// Combinational classifier for one CPU control write. ICW1 is recognised in
// every state; otherwise the meaning depends on the sequencer state.
// Ports:
//   state    : current sequencer state
//   wr_en    : write strobe
//   a0, din  : address bit and data of the write
//   wr_class : WR_NONE / WR_ICW1 / WR_NEXT / WR_OCW / WR_ERR
// ---------------------------------------------------------------------------
module icw_write_decode
    import pic_init_pkg::*;
(
    input  state_e     state,
    input  logic       wr_en,
    input  logic       a0,
    input  logic [7:0] din,
    output wr_class_e  wr_class
);

    // Classify the write; ICW1 takes priority over every state-specific meaning
    always_comb begin
        wr_class = WR_NONE;
        if (!wr_en) begin
            wr_class = WR_NONE;
        end else if (!a0 && din[ICW1_ID]) begin
            wr_class = WR_ICW1;
        end else begin
            case (state)
                ST_IDLE:  wr_class = WR_ERR;
                ST_WAIT2,
                ST_WAIT3,
                ST_WAIT4: begin
                    // a0=0 without the ID bit is neither ICW1 nor the awaited word
                    if (a0) begin
                        wr_class = WR_NEXT;
                    end else begin
                        wr_class = WR_ERR;
                    end
                end
                ST_READY: wr_class = WR_OCW;
                default:  wr_class = WR_ERR;
            endcase
        end
    end

endmodule

// File: rtl/icw_init_sequencer.sv
// ---------------------------------------------------------------------------
// icw_init_sequencer
// Initialization-command-word sequencer for an 8259-style PIC. Recognises
// ICW1 in any state, walks ICW2 -> ICW3 (cascade only) -> ICW4 (IC4 only),
// stores each word, decodes the mode fields for the priority/cascade logic,
// flags READY and forwards post-init writes as OCW strobes.
//
// Parameters:
//   NUM_IR : interrupt inputs per device, width of cascade_mask (2..8)
//   ID_W   : slave-ID width ($clog2(NUM_IR)..3)
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus             : CPU write bus (wr_en, a0, din), slave modport
//   init_done       : high in READY
//   expect_o        : next expected word (0=ICW1 .. 3=ICW4)
//   seq_err         : one-cycle pulse on an illegal write
//   ocw_wr/a0/data  : one-cycle OCW strobe with held address/data
//   icw1_o/2_o/4_o  : stored initialization words
//   level_trig, single_mode, addr_int4, vec_base : ICW1/ICW2 fields
//   cascade_mask, slave_id : ICW3 seen as master mask / slave identity
//   is_master, auto_eoi    : ICW4-derived flags
// Optional build macro ICW_READBACK_EN adds rd_sel (2) / rd_data (8): a
// registered readback of ICW1..ICW4 with one cycle of latency.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module icw_init_sequencer
    import pic_init_pkg::*;
#(
    parameter int NUM_IR = 8,
    parameter int ID_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icw_init_sequencer_if.slave   bus,
`ifdef ICW_READBACK_EN
    input  logic [1:0]            rd_sel,
    output logic [7:0]            rd_data,
`endif
    output logic                  init_done,
    output logic [1:0]            expect_o,
    output logic                  seq_err,
    output logic                  ocw_wr,
    output logic                  ocw_a0,
    output logic [7:0]            ocw_data,
    output logic [7:0]            icw1_o,
    output logic [7:0]            icw2_o,
    output logic [7:0]            icw4_o,
    output logic                  level_trig,
    output logic                  single_mode,
    output logic                  addr_int4,
    output logic [4:0]            vec_base,
    output logic [NUM_IR-1:0]     cascade_mask,
    output logic [ID_W-1:0]       slave_id,
    output logic                  is_master,
    output logic                  auto_eoi
);

    // ---------------- registers ----------------
    state_e               state_r;
    logic                 init_done_r;
    logic [1:0]           expect_r;
    logic                 seq_err_r;
    logic                 ocw_wr_r;
    logic                 ocw_a0_r;
    logic [7:0]           ocw_data_r;
    logic [7:0]           icw1_r;
    logic [7:0]           icw2_r;
    logic [7:0]           icw4_r;
    logic [NUM_IR-1:0]    cascade_mask_r;
    logic [ID_W-1:0]      slave_id_r;
    logic                 is_master_r;
    logic                 auto_eoi_r;

    // ---------------- next-state values ----------------
    state_e               state_s;
    logic                 seq_err_s;
    logic                 ocw_wr_s;
    logic                 ocw_a0_s;
    logic [7:0]           ocw_data_s;
    logic [7:0]           icw1_s;
    logic [7:0]           icw2_s;
    logic [7:0]           icw4_s;
    logic [NUM_IR-1:0]    cascade_mask_s;
    logic [ID_W-1:0]      slave_id_s;
    logic                 is_master_s;
    logic                 auto_eoi_s;
    wr_class_e            wr_class_s;

    icw_write_decode u_decode (
        .state    (state_r),
        .wr_en    (bus.wr_en),
        .a0       (bus.a0),
        .din      (bus.din),
        .wr_class (wr_class_s)
    );

    // Next-state and next-register computation; everything holds by default
    always_comb begin
        state_s        = state_r;
        seq_err_s      = 1'b0;
        ocw_wr_s       = 1'b0;
        ocw_a0_s       = ocw_a0_r;
        ocw_data_s     = ocw_data_r;
        icw1_s         = icw1_r;
        icw2_s         = icw2_r;
        icw4_s         = icw4_r;
        cascade_mask_s = cascade_mask_r;
        slave_id_s     = slave_id_r;
        is_master_s    = is_master_r;
        auto_eoi_s     = auto_eoi_r;

        case (wr_class_s)
            WR_ICW1: begin
                // Re-initialisation wipes everything learned from a previous ICW1
                icw1_s         = bus.din;
                icw2_s         = 8'h00;
                icw4_s         = 8'h00;
                cascade_mask_s = {NUM_IR{1'b0}};
                slave_id_s     = {ID_W{1'b0}};
                auto_eoi_s     = 1'b0;
                is_master_s    = 1'b1;
                state_s        = ST_WAIT2;
            end
            WR_NEXT: begin
                case (state_r)
                    ST_WAIT2: begin
                        icw2_s = bus.din;
                        if (!icw1_r[ICW1_SNGL]) begin
                            state_s = ST_WAIT3;
                        end else if (icw1_r[ICW1_IC4]) begin
                            state_s = ST_WAIT4;
                        end else begin
                            state_s = ST_READY;
                        end
                    end
                    ST_WAIT3: begin
                        // Master/slave role is not known until ICW4, so keep both views
                        cascade_mask_s = bus.din[NUM_IR-1:0];
                        slave_id_s     = bus.din[ID_W-1:0];
                        if (icw1_r[ICW1_IC4]) begin
                            state_s = ST_WAIT4;
                        end else begin
                            state_s = ST_READY;
                        end
                    end
                    ST_WAIT4: begin
                        icw4_s     = bus.din;
                        auto_eoi_s = bus.din[ICW4_AEOI];
                        // M/S bit only has meaning in buffered mode
                        if (bus.din[ICW4_BUF]) begin
                            is_master_s = bus.din[ICW4_MS];
                        end else begin
                            is_master_s = 1'b1;
                        end
                        state_s = ST_READY;
                    end
                    default: begin
                        state_s = state_r;
                    end
                endcase
            end
            WR_OCW: begin
                ocw_wr_s   = 1'b1;
                ocw_a0_s   = bus.a0;
                ocw_data_s = bus.din;
            end
            WR_ERR: begin
                seq_err_s = 1'b1;
            end
            default: begin
                state_s = state_r;
            end
        endcase
    end

    // State and data registers; status flags follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            init_done_r    <= 1'b0;
            expect_r       <= EXP_ICW1;
            seq_err_r      <= 1'b0;
            ocw_wr_r       <= 1'b0;
            ocw_a0_r       <= 1'b0;
            ocw_data_r     <= 8'h00;
            icw1_r         <= 8'h00;
            icw2_r         <= 8'h00;
            icw4_r         <= 8'h00;
            cascade_mask_r <= {NUM_IR{1'b0}};
            slave_id_r     <= {ID_W{1'b0}};
            is_master_r    <= 1'b1;
            auto_eoi_r     <= 1'b0;
        end else begin
            state_r        <= state_s;
            init_done_r    <= (state_s == ST_READY);
            expect_r       <= expect_of(state_s);
            seq_err_r      <= seq_err_s;
            ocw_wr_r       <= ocw_wr_s;
            ocw_a0_r       <= ocw_a0_s;
            ocw_data_r     <= ocw_data_s;
            icw1_r         <= icw1_s;
            icw2_r         <= icw2_s;
            icw4_r         <= icw4_s;
            cascade_mask_r <= cascade_mask_s;
            slave_id_r     <= slave_id_s;
            is_master_r    <= is_master_s;
            auto_eoi_r     <= auto_eoi_s;
        end
    end

`ifdef ICW_READBACK_EN
    logic [7:0] icw3_view_s;
    logic [7:0] rd_data_r;

    // Zero-extended ICW3 as seen by the current role
    always_comb begin
        icw3_view_s = 8'h00;
        if (is_master_r) begin
            icw3_view_s[NUM_IR-1:0] = cascade_mask_r;
        end else begin
            icw3_view_s[ID_W-1:0] = slave_id_r;
        end
    end

    // Registered readback mux, one cycle after rd_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 8'h00;
        end else begin
            case (rd_sel)
                2'd0:    rd_data_r <= icw1_r;
                2'd1:    rd_data_r <= icw2_r;
                2'd2:    rd_data_r <= icw3_view_s;
                2'd3:    rd_data_r <= icw4_r;
                default: rd_data_r <= 8'h00;
            endcase
        end
    end

    assign rd_data = rd_data_r;
`endif

    // ---------------- outputs (register-driven only) ----------------
    assign init_done    = init_done_r;
    assign expect_o     = expect_r;
    assign seq_err      = seq_err_r;
    assign ocw_wr       = ocw_wr_r;
    assign ocw_a0       = ocw_a0_r;
    assign ocw_data     = ocw_data_r;
    assign icw1_o       = icw1_r;
    assign icw2_o       = icw2_r;
    assign icw4_o       = icw4_r;
    assign level_trig   = icw1_r[ICW1_LTIM];
    assign single_mode  = icw1_r[ICW1_SNGL];
    assign addr_int4    = icw1_r[ICW1_ADI];
    assign vec_base     = icw2_r[7:3];
    assign cascade_mask = cascade_mask_r;
    assign slave_id     = slave_id_r;
    assign is_master    = is_master_r;
    assign auto_eoi     = auto_eoi_r;

endmodule

// File: tb/tb_icw_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_icw_init_sequencer
// Directed self-checking bench for icw_init_sequencer. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the write.
// ---------------------------------------------------------------------------
module tb_icw_init_sequencer;

    logic       clk;
    logic       rst_n;
    logic       init_done;
    logic [1:0] expect_o;
    logic       seq_err;
    logic       ocw_wr;
    logic       ocw_a0;
    logic [7:0] ocw_data;
    logic [7:0] icw1_o;
    logic [7:0] icw2_o;
    logic [7:0] icw4_o;
    logic       level_trig;
    logic       single_mode;
    logic       addr_int4;
    logic [4:0] vec_base;
    logic [7:0] cascade_mask;
    logic [2:0] slave_id;
    logic       is_master;
    logic       auto_eoi;
`ifdef ICW_READBACK_EN
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
`endif

    int n_cmp;
    int n_bad;

    icw_init_sequencer_if bus ();

    icw_init_sequencer #(.NUM_IR(8), .ID_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
`ifdef ICW_READBACK_EN
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
`endif
        .init_done    (init_done),
        .expect_o     (expect_o),
        .seq_err      (seq_err),
        .ocw_wr       (ocw_wr),
        .ocw_a0       (ocw_a0),
        .ocw_data     (ocw_data),
        .icw1_o       (icw1_o),
        .icw2_o       (icw2_o),
        .icw4_o       (icw4_o),
        .level_trig   (level_trig),
        .single_mode  (single_mode),
        .addr_int4    (addr_int4),
        .vec_base     (vec_base),
        .cascade_mask (cascade_mask),
        .slave_id     (slave_id),
        .is_master    (is_master),
        .auto_eoi     (auto_eoi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One write cycle; returns on the falling edge after the sampling edge
    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.a0    = a;
        bus.din   = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.a0    = 1'b0;
        bus.din   = 8'h00;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        bus.a0    = 1'b0;
        bus.din   = 8'h00;
`ifdef ICW_READBACK_EN
        rd_sel    = 2'd0;
`endif
        #12;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_expect",    {30'd0, expect_o},  32'd0);
        chk("rst_is_master", {31'd0, is_master}, 32'd1);
        chk("rst_icw1",      {24'd0, icw1_o},    32'h00);
        chk("rst_seq_err",   {31'd0, seq_err},   32'd0);
        chk("rst_ocw_wr",    {31'd0, ocw_wr},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-ICW1 write in IDLE
        wr(1'b1, 8'h40);
        chk("idle_err_pulse",  {31'd0, seq_err},  32'd1);
        chk("idle_err_expect", {30'd0, expect_o}, 32'd0);
        chk("idle_err_icw2",   {24'd0, icw2_o},   32'h00);
        idle();
        chk("idle_err_drop",   {31'd0, seq_err},  32'd0);

        // Single, IC4: ICW1 0x13, ICW2 0x48, ICW4 0x03
        wr(1'b0, 8'h13);
        chk("s1_expect", {30'd0, expect_o},    32'd1);
        chk("s1_icw1",   {24'd0, icw1_o},      32'h13);
        chk("s1_single", {31'd0, single_mode}, 32'd1);
        wr(1'b1, 8'h48);
        chk("s1_expect2",  {30'd0, expect_o}, 32'd3);
        chk("s1_vec_base", {27'd0, vec_base}, 32'h09);
        chk("s1_done_lo",  {31'd0, init_done}, 32'd0);
        wr(1'b1, 8'h03);
        chk("s1_done",     {31'd0, init_done}, 32'd1);
        chk("s1_expect3",  {30'd0, expect_o},  32'd0);
        chk("s1_aeoi",     {31'd0, auto_eoi},  32'd1);
        chk("s1_icw4",     {24'd0, icw4_o},    32'h03);
        chk("s1_master",   {31'd0, is_master}, 32'd1);

        // OCW forwarding in READY
        wr(1'b1, 8'hFF);
        chk("ocw_pulse", {31'd0, ocw_wr},    32'd1);
        chk("ocw_a0",    {31'd0, ocw_a0},    32'd1);
        chk("ocw_data",  {24'd0, ocw_data},  32'hFF);
        chk("ocw_done",  {31'd0, init_done}, 32'd1);
        idle();
        chk("ocw_drop",  {31'd0, ocw_wr},    32'd0);
        chk("ocw_hold",  {24'd0, ocw_data},  32'hFF);

        // Cascade master with IC4: 0x11, 0x20, 0xA5, 0x0D
        wr(1'b0, 8'h11);
        chk("c1_expect",  {30'd0, expect_o},  32'd1);
        chk("c1_done_lo", {31'd0, init_done}, 32'd0);
        chk("c1_icw4_clr",{24'd0, icw4_o},    32'h00);
        chk("c1_aeoi_clr",{31'd0, auto_eoi},  32'd0);
        wr(1'b1, 8'h20);
        chk("c1_expect2", {30'd0, expect_o},  32'd2);
        wr(1'b1, 8'hA5);
        chk("c1_expect3", {30'd0, expect_o},     32'd3);
        chk("c1_mask",    {24'd0, cascade_mask}, 32'hA5);
        chk("c1_sid",     {29'd0, slave_id},     32'd5);
        wr(1'b1, 8'h0D);
        chk("c1_master",  {31'd0, is_master}, 32'd1);
        chk("c1_icw4",    {24'd0, icw4_o},    32'h0D);
        chk("c1_aeoi",    {31'd0, auto_eoi},  32'd0);
        chk("c1_done",    {31'd0, init_done}, 32'd1);

        // Single without IC4: 0x12, 0x08 -> READY directly
        wr(1'b0, 8'h12);
        wr(1'b1, 8'h08);
        chk("s2_done",   {31'd0, init_done},    32'd1);
        chk("s2_expect", {30'd0, expect_o},     32'd0);
        chk("s2_icw4",   {24'd0, icw4_o},       32'h00);
        chk("s2_aeoi",   {31'd0, auto_eoi},     32'd0);
        chk("s2_vec",    {27'd0, vec_base},     32'h01);
        chk("s2_mask",   {24'd0, cascade_mask}, 32'h00);

        // Illegal a0=0 write mid-sequence, then restart from WAIT3
        wr(1'b0, 8'h19);
        chk("e_ltim",    {31'd0, level_trig}, 32'd1);
        wr(1'b0, 8'h05);
        chk("e_pulse",   {31'd0, seq_err},  32'd1);
        chk("e_expect",  {30'd0, expect_o}, 32'd1);
        chk("e_icw1",    {24'd0, icw1_o},   32'h19);
        wr(1'b1, 8'h30);
        chk("e_expect2", {30'd0, expect_o}, 32'd2);
        wr(1'b0, 8'h13);
        chk("r_expect",  {30'd0, expect_o},    32'd1);
        chk("r_icw2",    {24'd0, icw2_o},      32'h00);
        chk("r_single",  {31'd0, single_mode}, 32'd1);

        // Buffered slave: ICW4 0x08 clears is_master; ICW1 restores it
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h20);
        wr(1'b1, 8'h02);
        wr(1'b1, 8'h08);
        chk("b_master",  {31'd0, is_master}, 32'd0);
        chk("b_sid",     {29'd0, slave_id},  32'd2);
`ifdef ICW_READBACK_EN
        rd_sel = 2'd2;
        idle();
        chk("rb_icw3_slave", {24'd0, rd_data}, 32'h02);
        rd_sel = 2'd3;
        idle();
        chk("rb_icw4", {24'd0, rd_data}, 32'h08);
`endif
        wr(1'b0, 8'h13);
        chk("b_master_rst", {31'd0, is_master}, 32'd1);
        wr(1'b1, 8'h48);
        chk("w4_expect",    {30'd0, expect_o},  32'd3);

        // Asynchronous reset while in WAIT4, checked before the next edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_expect",  {30'd0, expect_o},  32'd0);
        chk("ar_icw1",    {24'd0, icw1_o},    32'h00);
        chk("ar_icw2",    {24'd0, icw2_o},    32'h00);
        chk("ar_done",    {31'd0, init_done}, 32'd0);
        chk("ar_master",  {31'd0, is_master}, 32'd1);
        chk("ar_ocw",     {24'd0, ocw_data},  32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
